// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Moore controller that issues one parallel load followed by a
//                clamped number of shift strobes, with abort/clear support.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_sequencer #(
  parameter int bitwidth = 16,
  parameter int cntwidth = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [cntwidth-1:0] shift_count,
  input  logic                abort,
  output logic                load,
  output logic                shift,
  output logic                clear,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [cntwidth-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [cntwidth-1:0] MAX_COUNT = cntwidth'(bitwidth);

  state_t              state_q, state_d;
  logic [cntwidth-1:0] remaining_q, remaining_d;
  logic                load_q, load_d;
  logic                shift_q, shift_d;
  logic                clear_q, clear_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      load_q      <= 1'b0;
      shift_q     <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_q      <= load_d;
      shift_q     <= shift_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start; the start is dropped
        if (abort) begin
          state_d     = S_ABORT;
          remaining_d = '0;
        end else if (start) begin
          state_d     = S_LOAD;
          remaining_d = (shift_count > MAX_COUNT) ? MAX_COUNT : shift_count;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d     = S_ABORT;
          remaining_d = '0;
        end else if (remaining_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d     = S_ABORT;
          remaining_d = '0;
        end else begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
          end
          if (remaining_q <= cntwidth'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d     = S_ABORT;
          remaining_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        state_d     = S_IDLE;
        remaining_d = '0;
      end
      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they leave the flops aligned
  // with the state they belong to.
  always_comb begin
    load_d    = (state_d == S_LOAD);
    shift_d   = (state_d == S_SHIFT);
    clear_d   = (state_d == S_ABORT);
    aborted_d = (state_d == S_ABORT);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  assign load      = load_q;
  assign shift     = shift_q;
  assign clear     = clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign remaining = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Directed bench for shift_sequencer with a timing-offset
//                reference model and literal spot checks.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam int BW = 16;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] shift_count = '0;
  logic          abort = 1'b0;
  logic          load, shift, clear, busy, done, aborted;
  logic [CW-1:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.bitwidth(BW), .cntwidth(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .shift_count(shift_count),
    .abort(abort), .load(load), .shift(shift), .clear(clear), .busy(busy),
    .done(done), .aborted(aborted), .remaining(remaining)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is described by the cycle of its load (lc)
  // and its length n; every output follows from the offset d = cyc - lc.
  int cyc = 0;
  int mode = 0;   // 0 idle, 1 sequence in flight, 2 abort cycle
  int lc = 0;
  int n = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode = 0;
    end else begin
      cyc++;
      case (mode)
        2: mode = 0;
        0: begin
          if (abort) mode = 2;
          else if (start) begin
            mode = 1;
            lc = cyc;
            n = (int'(shift_count) > BW) ? BW : int'(shift_count);
          end
        end
        default: begin
          if (abort) mode = 2;
          else if ((cyc - 1 - lc) == n + 1) mode = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    int d, e_load, e_shift, e_done, e_busy, e_abt, e_rem;
    d = cyc - lc;
    e_load = 0; e_shift = 0; e_done = 0; e_busy = 0; e_abt = 0; e_rem = 0;
    if (mode == 2) begin
      e_busy = 1; e_abt = 1;
    end else if (mode == 1) begin
      e_busy  = 1;
      e_load  = (d == 0) ? 1 : 0;
      e_shift = (d >= 1 && d <= n) ? 1 : 0;
      e_done  = (d == n + 1) ? 1 : 0;
      e_rem   = (d == 0) ? n : ((d <= n) ? n - d + 1 : 0);
    end
    check("model_load", int'(load), e_load);
    check("model_shift", int'(shift), e_shift);
    check("model_done", int'(done), e_done);
    check("model_busy", int'(busy), e_busy);
    check("model_clear", int'(clear), e_abt);
    check("model_aborted", int'(aborted), e_abt);
    check("model_remaining", int'(remaining), e_rem);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run_until_done(output int shifts, output int loads);
    bit seen;
    seen = 0; shifts = 0; loads = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (shift) shifts++;
      if (load) loads++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_within_budget", int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, l, idle_cnt, run, max_run;

    #3;
    check("rst_load", int'(load), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_remaining", int'(remaining), 0);
    tick(); tick();
    reset = 1'b1;

    // Normal sequence, N = 5
    start = 1'b1; shift_count = 5'd5;
    tick();
    start = 1'b0;
    check("n5_load", int'(load), 1);
    check("n5_rem_load", int'(remaining), 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("n5_shift", int'(shift), 1);
      check("n5_rem", int'(remaining), 5 - i);
    end
    tick();
    check("n5_done", int'(done), 1);
    check("n5_rem_done", int'(remaining), 0);
    tick();
    check("n5_idle", int'(busy), 0);

    // Zero count
    start = 1'b1; shift_count = 5'd0;
    tick();
    start = 1'b0;
    check("z_load", int'(load), 1);
    tick();
    check("z_done", int'(done), 1);
    check("z_noshift", int'(shift), 0);
    tick();

    // Clamp 31 -> 16
    start = 1'b1; shift_count = 5'd31;
    tick();
    start = 1'b0;
    check("clamp_rem", int'(remaining), 16);
    run_until_done(s, l);
    check("clamp_shifts", s, 16);
    tick();

    // Abort in the 3rd shift cycle
    start = 1'b1; shift_count = 5'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("ab_in_shift3", int'(shift), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_shift_low", int'(shift), 0);
    check("ab_clear", int'(clear), 1);
    check("ab_aborted", int'(aborted), 1);
    check("ab_nodone", int'(done), 0);
    tick();
    check("ab_idle", int'(busy), 0);
    check("ab_clear_once", int'(clear), 0);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1; shift_count = 5'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    check("col_clear", int'(clear), 1);
    check("col_noload", int'(load), 0);
    tick();
    check("col_idle", int'(busy), 0);
    check("col_dropped", int'(load), 0);

    // Start while busy is ignored
    start = 1'b1; shift_count = 5'd3;
    tick();
    start = 1'b0;
    tick();
    s = int'(shift);
    start = 1'b1; shift_count = 5'd7;
    tick();
    if (shift) s++;
    start = 1'b0;
    begin
      int s2, l2;
      run_until_done(s2, l2);
      check("busy_start_shifts", s + s2, 3);
    end
    tick();
    tick();
    check("busy_start_not_queued", int'(load), 0);

    // Reset mid-sequence
    start = 1'b1; shift_count = 5'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    check("rst_mid_shift", int'(shift), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_rem", int'(remaining), 0);
    tick(); tick();
    check("rst_hold_done", int'(done), 0);
    reset = 1'b1;
    start = 1'b1; shift_count = 5'd2;
    tick();
    start = 1'b0;
    check("post_rst_load", int'(load), 1);
    run_until_done(s, l);
    check("post_rst_shifts", s, 2);
    tick();

    // Back-to-back with start held high
    start = 1'b1; shift_count = 5'd2;
    s = 0; l = 0; idle_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (shift) s++;
      if (load) l++;
      if (!busy) begin
        idle_cnt++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    start = 1'b0;
    check("b2b_loads", l, 3);
    check("b2b_shifts", s, 6);
    check("b2b_idle_cycles", idle_cnt, 3);
    check("b2b_idle_run", max_run, 1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: bitwidth, default 16, width of the controlled shift register; legal range 2..256.
REQ-002 Parameter: cntwidth, default 5, width of the shift count; SHALL satisfy 2**cntwidth > bitwidth.
REQ-003 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request one load-then-shift sequence; sampled only in IDLE.
REQ-006 Port: shift_count  input  cntwidth  number of shifts requested; sampled with start.
REQ-007 Port: abort  input  1  terminate the active sequence and clear the shifter.
REQ-008 Port: load  output  1  shifter parallel-load strobe.
REQ-009 Port: shift  output  1  shifter shift-enable strobe.
REQ-010 Port: clear  output  1  shifter clear strobe, active high.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on normal completion.
REQ-013 Port: aborted  output  1  one-cycle pulse on abort completion.
REQ-014 Port: remaining  output  cntwidth  shifts still to be issued.

Function
REQ-015 All outputs SHALL be registered (Moore); no combinational path from any input to any output.
REQ-016 States SHALL be IDLE, LOAD, SHIFT, DONE and ABORT.
REQ-017 IDLE: start=1 and abort=0 -> LOAD; remaining latches min(shift_count, bitwidth).
REQ-018 LOAD: load=1 for exactly one cycle; -> DONE if remaining=0, else -> SHIFT.
REQ-019 SHIFT: shift=1 every cycle; remaining decrements by 1 per cycle; -> DONE in the cycle in which remaining goes 1->0.
REQ-020 DONE: done=1 for one cycle, then -> IDLE.
REQ-021 Latency: with start sampled at edge k and N = min(shift_count, bitwidth), load is high in cycle k+1, shift is high in cycles k+2..k+1+N, and done is high in cycle k+2+N.
REQ-022 load and shift SHALL never be high in the same cycle; shift SHALL be high for exactly N cycles per completed sequence.
REQ-023 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-024 abort=1 sampled in LOAD, SHIFT or DONE -> ABORT next cycle; load and shift SHALL go low at that edge.
REQ-025 ABORT: clear=1 and aborted=1 for one cycle; remaining set to 0; -> IDLE; done SHALL NOT pulse for that sequence.
REQ-026 abort=1 in IDLE -> ABORT (shifter clear pulse); abort SHALL take priority over a simultaneous start, and that start SHALL be dropped.
REQ-027 abort sampled in ABORT SHALL have no further effect; the sequence returns to IDLE.
REQ-028 shift_count greater than bitwidth SHALL be clamped to bitwidth; shift_count=0 SHALL yield LOAD then DONE with no shift cycle.
REQ-029 remaining SHALL never wrap below 0.

Reset
REQ-030 reset=0 SHALL asynchronously force the state to IDLE and drive load, shift, clear, busy, done, aborted to 0 and remaining to 0.
REQ-031 reset asserted mid-sequence SHALL abandon the sequence; no done or aborted pulse follows.
REQ-032 After reset deassertion, the first start SHALL be accepted at the first rising edge on which it is sampled.

Verification
REQ-033 Normal sequence: bitwidth=16, start=1 with shift_count=5 at edge 0 -> load in cycle 1, shift in cycles 2-6, done in cycle 7, remaining steps 5,4,3,2,1,0.
REQ-034 Zero count and clamp: shift_count=0 -> load in cycle 1, done in cycle 2, shift never high; shift_count=31 -> exactly 16 shift cycles.
REQ-035 Abort mid-shift: shift_count=8, abort in the 3rd shift cycle -> shift low next cycle, clear=1 and aborted=1 for one cycle, busy=0 the cycle after, done never high.
REQ-036 Start+abort collision in IDLE -> one clear pulse, no load; start while busy during SHIFT -> ignored, sequence length unchanged.
REQ-037 Reset mid-sequence: reset low for 2 cycles during SHIFT -> all outputs 0 immediately, without waiting for a clock edge; a new start after release runs a full sequence.
REQ-038 Back-to-back: start held high continuously with shift_count=2 -> sequences repeat; busy is low for exactly one cycle between them, and each sequence gives exactly 1 load and 2 shifts.
